adder_tree_accum: RTL and testbench

Frame accumulator that sits directly downstream of the 8-input, 3-level adder tree. It consumes one full-width tree sum per valid cycle and accumulates `frame_len` consecutive sums into a frame total. It then presents that total on a valid/ready output register. Accumulation of the next frame continues while a finished result waits, so the free-running tree never has to stall.

---
 rtl/adder_tree_pkg.sv | 16 +
 rtl/adder_tree_out_reg.sv | 55 +++++
 rtl/adder_tree_accum.sv | 108 ++++++++++
 tb/tb_adder_tree_accum.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Shared constants and state encodings for the adder tree and its frame accumulator.
package adder_tree_pkg;

  localparam int ADDER_WIDTH = 28;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_RUN  = 1'b1
  } acc_state_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/adder_tree_out_reg.sv
// One-entry valid/ready holding register; a load into a full, unaccepted entry is dropped
// and reported on drop one cycle later.
module adder_tree_out_reg
  import adder_tree_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  drop
);

  out_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  drop_q, drop_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    drop_d  = 1'b0;
    if (load) begin
      // A result may replace the held one only if it leaves in the same cycle.
      if (state_q == OUT_EMPTY || out_ready) begin
        data_d  = load_data;
        state_d = OUT_FULL;
      end else begin
        drop_d = 1'b1;
      end
    end else if (state_q == OUT_FULL && out_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid = (state_q == OUT_FULL);
  assign out_data  = data_q;
  assign drop      = drop_q;

endmodule

// File: rtl/adder_tree_accum.sv
// Frame accumulator behind the adder tree: sums frame_len tree outputs per frame and
// hands the total to a holding register without ever stalling the tree.
module adder_tree_accum
  import adder_tree_pkg::*;
#(
  parameter int IN_WIDTH    = 31,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [IN_WIDTH-1:0]             in_sum,
  input  logic [COUNT_WIDTH-1:0]          frame_len,
  input  logic                            clear,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [IN_WIDTH+COUNT_WIDTH-1:0] out_sum,
  output logic [COUNT_WIDTH-1:0]          out_count,
  output logic                            busy,
  output logic                            overrun
);

  localparam int ACC_WIDTH = IN_WIDTH + COUNT_WIDTH;

  acc_state_t             state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] len_q, len_d;

  logic [COUNT_WIDTH-1:0] len_eff;
  logic [ACC_WIDTH-1:0]   sum_ext;
  logic [ACC_WIDTH-1:0]   acc_sum;
  logic [COUNT_WIDTH-1:0] count_inc;
  logic                   complete;
  logic [ACC_WIDTH-1:0]   result_sum;
  logic [COUNT_WIDTH-1:0] result_count;

  assign len_eff   = (frame_len == '0) ? COUNT_WIDTH'(1) : frame_len;
  assign sum_ext   = {{COUNT_WIDTH{1'b0}}, in_sum};
  assign acc_sum   = acc_q + sum_ext;
  assign count_inc = count_q + COUNT_WIDTH'(1);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    len_d        = len_q;
    complete     = 1'b0;
    result_sum   = acc_sum;
    result_count = len_q;
    if (clear) begin
      state_d = ACC_IDLE;
      acc_d   = '0;
      count_d = '0;
    end else if (in_valid) begin
      if (state_q == ACC_IDLE) begin
        len_d        = len_eff;
        result_sum   = sum_ext;
        result_count = len_eff;
        if (len_eff == COUNT_WIDTH'(1)) begin
          complete = 1'b1;
        end else begin
          acc_d   = sum_ext;
          count_d = COUNT_WIDTH'(1);
          state_d = ACC_RUN;
        end
      end else if (count_inc == len_q) begin
        complete = 1'b1;
        acc_d    = '0;
        count_d  = '0;
        state_d  = ACC_IDLE;
      end else begin
        acc_d   = acc_sum;
        count_d = count_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

  adder_tree_out_reg #(
    .DATA_WIDTH(ACC_WIDTH + COUNT_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (complete),
    .load_data({result_count, result_sum}),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data ({out_count, out_sum}),
    .drop     (overrun)
  );

  assign busy = (state_q == ACC_RUN);

endmodule

// File: tb/tb_adder_tree_accum.sv
// Directed bench for adder_tree_accum: hand-computed frame totals, handshake, overrun,
// clear and asynchronous reset behaviour.
module tb_adder_tree_accum;

  localparam int IN_WIDTH    = 31;
  localparam int COUNT_WIDTH = 8;
  localparam int ACC_WIDTH   = IN_WIDTH + COUNT_WIDTH;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic [IN_WIDTH-1:0]    in_sum;
  logic [COUNT_WIDTH-1:0] frame_len;
  logic                   clear;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_WIDTH-1:0]   out_sum;
  logic [COUNT_WIDTH-1:0] out_count;
  logic                   busy;
  logic                   overrun;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_tree_accum #(
    .IN_WIDTH   (IN_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sum   (in_sum),
    .frame_len(frame_len),
    .clear    (clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .busy     (busy),
    .overrun  (overrun)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; one line per accepted result.
  task automatic tick();
    @(posedge clk);
    #1;
    if (out_valid && out_ready)
      $display("txn t=%0t out_sum=%0d out_count=%0d", $time, out_sum, out_count);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [63:0] s,
                         input logic [63:0] c);
    chk({tag, ".valid"}, {63'd0, out_valid}, {63'd0, v});
    chk({tag, ".sum"}, {25'd0, out_sum}, s);
    chk({tag, ".count"}, {56'd0, out_count}, c);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; frame_len = '0;
    clear = 1'b0; out_ready = 1'b0;
    #12;
    chk_out("reset", 1'b0, 0, 0);
    chk("reset.busy", {63'd0, busy}, 0);
    chk("reset.overrun", {63'd0, overrun}, 0);
    rst_n = 1'b1;
    tick();

    // Frame of four: 10+20+30+40
    frame_len = 8'd4; out_ready = 1'b1; in_valid = 1'b1;
    in_sum = 31'd10; tick(); chk("f4.busy1", {63'd0, busy}, 1); chk("f4.nov1", {63'd0, out_valid}, 0);
    in_sum = 31'd20; tick(); chk("f4.busy2", {63'd0, busy}, 1); chk("f4.nov2", {63'd0, out_valid}, 0);
    in_sum = 31'd30; tick(); chk("f4.busy3", {63'd0, busy}, 1); chk("f4.nov3", {63'd0, out_valid}, 0);
    in_sum = 31'd40; tick(); chk("f4.busy4", {63'd0, busy}, 0); chk_out("f4", 1'b1, 100, 4);
    in_valid = 1'b0; tick(); chk("f4.after", {63'd0, out_valid}, 0);

    // frame_len 0 acts as 1: every sample is a frame
    frame_len = 8'd0; in_valid = 1'b1;
    in_sum = 31'd5; tick(); chk_out("len0.a", 1'b1, 5, 1); chk("len0.busy", {63'd0, busy}, 0);
    in_sum = 31'd6; tick(); chk_out("len0.b", 1'b1, 6, 1);
    in_sum = 31'd7; tick(); chk_out("len0.c", 1'b1, 7, 1);
    in_valid = 1'b0; tick(); chk("len0.after", {63'd0, out_valid}, 0);

    // Overrun: second frame dropped while the first is held
    frame_len = 8'd2; out_ready = 1'b0; in_valid = 1'b1;
    in_sum = 31'd1; tick(); chk("ovr.busy", {63'd0, busy}, 1);
    in_sum = 31'd2; tick(); chk_out("ovr.first", 1'b1, 3, 2);
    in_sum = 31'd3; tick(); chk("ovr.nopulse", {63'd0, overrun}, 0);
    in_sum = 31'd4; tick(); chk("ovr.pulse", {63'd0, overrun}, 1); chk_out("ovr.held", 1'b1, 3, 2);
    in_valid = 1'b0; tick(); chk("ovr.pulse_end", {63'd0, overrun}, 0); chk_out("ovr.held2", 1'b1, 3, 2);
    out_ready = 1'b1; tick(); chk("ovr.drained", {63'd0, out_valid}, 0);

    // Maximum frame with maximum samples: 255 * (2^31 - 1)
    frame_len = 8'd255; in_valid = 1'b1; in_sum = 31'h7FFF_FFFF;
    for (int i = 0; i < 254; i++) tick();
    chk("max.busy", {63'd0, busy}, 1); chk("max.nov", {63'd0, out_valid}, 0);
    tick(); chk_out("max", 1'b1, 64'd547608329985, 255);
    in_valid = 1'b0; tick();

    // Clear mid-frame discards progress and the concurrent sample
    frame_len = 8'd4; in_valid = 1'b1; in_sum = 31'd1;
    tick(); tick(); chk("clr.busy_before", {63'd0, busy}, 1);
    clear = 1'b1; in_sum = 31'd100; tick();
    chk("clr.busy", {63'd0, busy}, 0); chk("clr.nov", {63'd0, out_valid}, 0);
    clear = 1'b0; in_sum = 31'd1;
    tick(); tick(); tick(); tick(); chk_out("clr.frame", 1'b1, 4, 4);
    in_valid = 1'b0; tick();

    // Asynchronous reset mid-frame
    frame_len = 8'd3; out_ready = 1'b0; in_valid = 1'b1; in_sum = 31'd7;
    tick(); chk("rst1.busy_before", {63'd0, busy}, 1);
    in_valid = 1'b0; #1; rst_n = 1'b0; #1;
    chk("rst1.busy", {63'd0, busy}, 0); chk_out("rst1", 1'b0, 0, 0);
    #1; rst_n = 1'b1;
    // Asynchronous reset with a result held
    in_valid = 1'b1;
    in_sum = 31'd7; tick(); in_sum = 31'd8; tick(); in_sum = 31'd9; tick();
    chk_out("rst2.held", 1'b1, 24, 3);
    in_valid = 1'b0; #1; rst_n = 1'b0; #1;
    chk_out("rst2", 1'b0, 0, 0); chk("rst2.overrun", {63'd0, overrun}, 0);
    #1; rst_n = 1'b1;
    // Clean frame after reset: no residue
    frame_len = 8'd2; out_ready = 1'b1; in_valid = 1'b1;
    in_sum = 31'd5; tick(); in_sum = 31'd6; tick();
    chk_out("post_rst", 1'b1, 11, 2);
    in_valid = 1'b0; tick(); chk("post_rst.after", {63'd0, out_valid}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
